board_reader: RTL and testbench
===============================

# board_reader

Streams the 4x4 game board (`matriz`, 12-bit tile values) to a display renderer one cell at a time over a valid/ready handshake. It is the read side of the board interface that the game top writes.
- Snapshots the board at each frame request, so a move landing mid-scan never tears the frame.
- Converts each tile value to a 4-bit log2 code.
- Reports per-frame status: highest code, goal reached, illegal-value error.

## Interface
Parameters:
- `GOAL`, 2048: winning tile value; must be a power of two between 2 and 2048.
- `W`, 12: tile value width.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset, asynchronous, active-low.
- `matriz`  in  W x [0:3][0:3]  live board from the game.
- `frame_start`  in  1  one-cycle frame request from the renderer.
- `cell_valid`  out  1  beat valid.
- `cell_ready`  in  1  renderer accepts the beat.
- `cell_row`  out  2  row index of the beat.
- `cell_col`  out  2  column index of the beat.
- `cell_code`  out  4  tile code of the beat.
- `cell_last`  out  1  final beat of the frame.
- `busy`  out  1  high from snapshot until `done`.
- `done`  out  1  one-cycle end-of-frame pulse.
- `max_code`  out  4  highest code in the last frame; updates on `done`.
- `goal_seen`  out  1  last frame contained `GOAL`; updates on `done`.
- `err`  out  1  sticky; set by an illegal tile value, cleared only by reset.

## Operation
FSM states: IDLE, SCAN, DONE.
- **IDLE:**
  - On `frame_start`: copy `matriz` into the snapshot, clear the cell index and the running max, go to SCAN.
  - Otherwise stay.
- **SCAN:**
  - `cell_valid` high; row, col and code come from the snapshot at the current index, in row-major order 0..15.
  - A handshake (`cell_valid && cell_ready`) advances the index and folds the code into the running max.
  - The handshake on the last beat goes to DONE.
  - `frame_start` in SCAN or DONE is ignored; there is no queueing.
- **DONE:**
  - Pulse `done` for one cycle.
  - Load `max_code` and `goal_seen`.
  - Return to IDLE.

Encoding (combinational, `tile_encoder`):
- 0 -> code 0.
- 2^k for k = 1..11 -> code k.
- Any other value -> code 4'hF, which sets `err` when that beat handshakes.
- Code 4'hF is excluded from `max_code`.

`goal_seen` is set when any handshaked code equals log2(`GOAL`).

Output stability: while `cell_valid` is high and `cell_ready` is low, row, col, code and last hold constant.

## Timing
- Reset values: every output is 0, state is IDLE, snapshot is cleared.
- `frame_start` sampled at edge N -> `busy` and `cell_valid` high from cycle N+1.
- With `cell_ready` held high: 16 beats on cycles N+1..N+16, `done` on N+17, `busy` low from N+18.
- Each extra ready-low cycle delays everything after it by one cycle.
- `frame_start` that coincides with `done` is dropped; the next request is accepted from IDLE.
- `matriz` changes after the snapshot cycle do not affect the frame in flight.
- Reset asserted mid-frame:
  - Outputs go to reset values immediately.
  - No `done` is issued for the aborted frame.
  - `max_code` and `goal_seen` return to 0.

## Configuration
`BOARD_READER_SKIP_EMPTY_EN`:
- **Defined:**
  - Cells with code 0 are not emitted; the index skips over them within the same cycle.
  - `cell_last` marks the final non-empty cell, found by combinational lookahead over the remaining snapshot cells.
  - An all-empty board goes from IDLE straight to DONE with zero beats, giving `done` at N+1.
- **Undefined:** all 16 cells are always emitted.

## Structure
- Package `board_pkg`:
  - `tile_t` typedef (`logic [W-1:0]`) and `board_t` typedef ([0:3][0:3] of `tile_t`).
  - Constants `CODE_EMPTY` = 0 and `CODE_BAD` = 4'hF.
  - State enum `br_state_e`.
  - Function returning log2 of `GOAL`.
- One sub-module: `tile_encoder`, combinational value -> code (plus an illegal flag), instanced once on the current snapshot cell.

## Test plan
- Reset, then empty board, `frame_start`, ready held high -> 16 beats, all code 0, rows/cols 0,0..3,3, `cell_last` only on beat 16, `done` at N+17, `max_code` = 0.
- Board with [0][0]=2, [1][2]=64, [3][3]=2048 -> codes 1, 6, 11 at beats 0, 6, 15; `max_code` = 11; `goal_seen` = 1.
- Ready toggled on/off every cycle -> outputs stable while ready is low; 16 beats; `done` at N+32.
- `matriz` changed and `frame_start` re-pulsed mid-scan -> frame matches the original snapshot; no restart.
- [2][1]=6 -> beat 9 code 4'hF; `err` = 1 and stays set across the next frame; `max_code` ignores it.
- `BOARD_READER_SKIP_EMPTY_EN` defined, only [1][1]=4 and [3][0]=8 nonzero -> 2 beats, codes 2 then 3, `cell_last` on beat 2; all-empty board gives `done` at N+1 with no beats.

Source files
------------

// File: rtl/board_pkg.sv
// board_pkg: shared types, constants and helpers for the board read path.
//   tile_t / board_t : tile value and 4x4 board types
//   CODE_EMPTY       : code of an empty cell (value 0)
//   CODE_BAD         : code of an illegal tile value
//   br_state_e       : board_reader scan FSM states
//   goal_log2()      : log2 of the winning tile value
package board_pkg;

    localparam int unsigned TILE_W = 12;

    typedef logic [TILE_W-1:0] tile_t;
    typedef tile_t [0:3][0:3]  board_t;

    localparam logic [3:0] CODE_EMPTY = 4'h0;
    localparam logic [3:0] CODE_BAD   = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_DONE
    } br_state_e;

    function automatic logic [3:0] goal_log2(input int unsigned goal);
        logic [3:0] r;
        r = '0;
        for (int unsigned k = 1; k < 12; k++) begin
            if (goal == (32'd1 << k)) r = k[3:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/tile_encoder.sv
// tile_encoder: combinational tile value -> 4-bit log2 code.
//   value_i : tile value (W bits)
//   code_o  : 0 for empty, k for 2^k (k = 1..11), CODE_BAD otherwise
//   bad_o   : high when value_i is not a legal tile value
module tile_encoder
    import board_pkg::*;
#(
    parameter int unsigned W = 12
) (
    input  logic [W-1:0] value_i,
    output logic [3:0]   code_o,
    output logic         bad_o
);

    always_comb begin
        code_o = CODE_BAD;
        bad_o  = 1'b1;
        if (value_i == '0) begin
            code_o = CODE_EMPTY;
            bad_o  = 1'b0;
        end else begin
            for (int unsigned k = 1; k < 12; k++) begin
                if (value_i == (W'(1) << k)) begin
                    code_o = k[3:0];
                    bad_o  = 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/board_reader.sv
// board_reader: snapshots the 4x4 game board on a frame request and streams
// it cell by cell (row-major) over a valid/ready handshake as log2 codes.
//   clk, rst              : clock, asynchronous active-low reset
//   matriz                : live board from the game
//   frame_start           : one-cycle frame request (ignored unless idle)
//   cell_valid/cell_ready : beat handshake
//   cell_row/col/code/last: beat payload
//   busy, done            : frame in flight, one-cycle end-of-frame pulse
//   max_code, goal_seen   : per-frame status, loaded at end of frame
//   err                   : sticky illegal-tile flag
// Build option: define BOARD_READER_SKIP_EMPTY_EN to suppress empty cells.
module board_reader
    import board_pkg::*;
#(
    parameter int unsigned GOAL = 2048,
    parameter int unsigned W    = 12
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [0:3][0:3][W-1:0]  matriz,
    input  logic                    frame_start,
    output logic                    cell_valid,
    input  logic                    cell_ready,
    output logic [1:0]              cell_row,
    output logic [1:0]              cell_col,
    output logic [3:0]              cell_code,
    output logic                    cell_last,
    output logic                    busy,
    output logic                    done,
    output logic [3:0]              max_code,
    output logic                    goal_seen,
    output logic                    err
);

    localparam logic [3:0] GOAL_CODE = goal_log2(GOAL);

    br_state_e            state_q, state_d;
    logic [15:0][W-1:0]   snap_q, snap_d;
    logic [3:0]           idx_q, idx_d;
    logic [3:0]           run_max_q, run_max_d;
    logic                 run_goal_q, run_goal_d;
    logic [3:0]           max_q, max_d;
    logic                 goal_q, goal_d;
    logic                 err_q, err_d;

    logic [15:0][W-1:0]   board_flat;
    logic [3:0]           cur_idx;
    logic                 cur_last;
    logic [3:0]           code;
    logic                 bad;
    logic                 hs;

    always_comb begin
        for (int unsigned k = 0; k < 16; k++) begin
            board_flat[k[3:0]] = matriz[k[3:2]][k[1:0]];
        end
    end

`ifdef BOARD_READER_SKIP_EMPTY_EN
    logic found;
    // The emitted cell is the first non-empty one at or after idx_q; it is
    // last when no other non-empty cell follows it.
    always_comb begin
        cur_idx  = idx_q;
        cur_last = 1'b1;
        found    = 1'b0;
        for (int unsigned i = 0; i < 16; i++) begin
            if (32'(idx_q) <= i && snap_q[i[3:0]] != '0) begin
                if (!found) begin
                    cur_idx = i[3:0];
                    found   = 1'b1;
                end else begin
                    cur_last = 1'b0;
                end
            end
        end
    end
`else
    always_comb begin
        cur_idx  = idx_q;
        cur_last = (idx_q == 4'd15);
    end
`endif

    tile_encoder #(.W(W)) u_enc (
        .value_i (snap_q[cur_idx]),
        .code_o  (code),
        .bad_o   (bad)
    );

    assign cell_valid = (state_q == ST_SCAN);
    assign cell_row   = cell_valid ? cur_idx[3:2] : 2'b00;
    assign cell_col   = cell_valid ? cur_idx[1:0] : 2'b00;
    assign cell_code  = cell_valid ? code : 4'h0;
    assign cell_last  = cell_valid && cur_last;
    assign busy       = (state_q != ST_IDLE);
    assign done       = (state_q == ST_DONE);
    assign max_code   = max_q;
    assign goal_seen  = goal_q;
    assign err        = err_q;
    assign hs         = cell_valid && cell_ready;

    always_comb begin
        state_d    = state_q;
        snap_d     = snap_q;
        idx_d      = idx_q;
        run_max_d  = run_max_q;
        run_goal_d = run_goal_q;
        max_d      = max_q;
        goal_d     = goal_q;
        err_d      = err_q;
        case (state_q)
            ST_IDLE: begin
                if (frame_start) begin
                    snap_d     = board_flat;
                    idx_d      = '0;
                    run_max_d  = '0;
                    run_goal_d = 1'b0;
                    state_d    = ST_SCAN;
`ifdef BOARD_READER_SKIP_EMPTY_EN
                    if (board_flat == '0) state_d = ST_DONE;
`endif
                end
            end
            ST_SCAN: begin
                if (hs) begin
                    idx_d = cur_idx + 4'd1;
                    if (bad) err_d = 1'b1;
                    else if (code > run_max_q) run_max_d = code;
                    if (code == GOAL_CODE) run_goal_d = 1'b1;
                    if (cur_last) state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                max_d   = run_max_q;
                goal_d  = run_goal_q;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            snap_q     <= '0;
            idx_q      <= '0;
            run_max_q  <= '0;
            run_goal_q <= 1'b0;
            max_q      <= '0;
            goal_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            snap_q     <= snap_d;
            idx_q      <= idx_d;
            run_max_q  <= run_max_d;
            run_goal_q <= run_goal_d;
            max_q      <= max_d;
            goal_q     <= goal_d;
            err_q      <= err_d;
        end
    end

endmodule

// File: tb/tb_board_reader.sv
module tb_board_reader;

`ifdef BOARD_READER_SKIP_EMPTY_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    typedef struct {
        int row;
        int col;
        int code;
        int last;
    } beat_t;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [0:3][0:3][11:0]   matriz;
    logic                    frame_start;
    logic                    cell_valid;
    logic                    cell_ready;
    logic [1:0]              cell_row;
    logic [1:0]              cell_col;
    logic [3:0]              cell_code;
    logic                    cell_last;
    logic                    busy;
    logic                    done;
    logic [3:0]              max_code;
    logic                    goal_seen;
    logic                    err;

    int n_vec = 0;
    int n_err = 0;

    int brd [4][4];
    int prev_max  = 0;
    int prev_goal = 0;
    int err_m     = 0;

    board_reader #(.GOAL(2048), .W(12)) dut (
        .clk         (clk),
        .rst         (rst),
        .matriz      (matriz),
        .frame_start (frame_start),
        .cell_valid  (cell_valid),
        .cell_ready  (cell_ready),
        .cell_row    (cell_row),
        .cell_col    (cell_col),
        .cell_code   (cell_code),
        .cell_last   (cell_last),
        .busy        (busy),
        .done        (done),
        .max_code    (max_code),
        .goal_seen   (goal_seen),
        .err         (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference encoding: legal tiles are 0 and powers of two from 2 to 2048.
    function automatic int enc(input int v);
        if (v == 0) return 0;
        if (v >= 2 && v <= 2048 && (v & (v - 1)) == 0) return $clog2(v);
        return 15;
    endfunction

    task automatic clear_board();
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) brd[r][c] = 0;
    endtask

    task automatic gen_board(input int zero_pct, input int bad_pct);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                if ($urandom_range(0, 99) < zero_pct) brd[r][c] = 0;
                else if ($urandom_range(0, 99) < bad_pct) brd[r][c] = 3 + 2 * $urandom_range(0, 500);
                else brd[r][c] = 1 << $urandom_range(1, 11);
            end
    endtask

    task automatic apply_board();
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) matriz[r[1:0]][c[1:0]] = 12'(brd[r][c]);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"},  32'(busy), 0);
        check({tag, "_valid"}, 32'(cell_valid), 0);
        check({tag, "_done"},  32'(done), 0);
        check({tag, "_max"},   32'(max_code), 0);
        check({tag, "_goal"},  32'(goal_seen), 0);
        check({tag, "_err"},   32'(err), 0);
        check({tag, "_row"},   32'(cell_row), 0);
        check({tag, "_col"},   32'(cell_col), 0);
        check({tag, "_code"},  32'(cell_code), 0);
        check({tag, "_last"},  32'(cell_last), 0);
    endtask

    // rmode: 0 ready always high, 1 ready high on odd cycles, 2 random.
    task automatic run_frame(input int rmode, input bit mid, input bit coincide);
        beat_t q[$];
        beat_t b;
        bit    rdy [0:255];
        int    exp_max  = 0;
        int    exp_goal = 0;
        int    bad      = 0;
        int    done_k;
        int    cnt;
        int    code;
        for (int i = 0; i < 16; i++) begin
            code = enc(brd[i / 4][i % 4]);
            if (!(SKIP && brd[i / 4][i % 4] == 0)) begin
                b.row = i / 4; b.col = i % 4; b.code = code; b.last = 0;
                q.push_back(b);
                if (code == 15) bad = 1;
                else if (code > exp_max) exp_max = code;
                if (code == 11) exp_goal = 1;
            end
        end
        if (q.size() > 0) q[q.size() - 1].last = 1;
        for (int k = 0; k < 256; k++) begin
            if (rmode == 0 || k > 100) rdy[k] = 1'b1;
            else if (rmode == 1)       rdy[k] = (k % 2 == 1);
            else                       rdy[k] = ($urandom_range(0, 3) != 0);
        end
        done_k = 1;
        cnt = 0;
        while (cnt < q.size()) begin
            if (rdy[done_k]) cnt++;
            done_k++;
        end

        apply_board();
        frame_start = 1'b1;
        @(posedge clk); #1;
        frame_start = 1'b0;
        for (int k = 1; k <= done_k + 2; k++) begin
            cell_ready  = rdy[k];
            frame_start = (mid && k == 3 && k < done_k) || (coincide && k == done_k);
            if (mid && k == 3) begin
                for (int r = 0; r < 4; r++)
                    for (int c = 0; c < 4; c++) matriz[r[1:0]][c[1:0]] = 12'($urandom);
            end
            check("busy",  32'(busy),       32'(k <= done_k));
            check("done",  32'(done),       32'(k == done_k));
            check("valid", 32'(cell_valid), 32'(k < done_k));
            if (k < done_k && q.size() > 0) begin
                check("row",  32'(cell_row),  q[0].row);
                check("col",  32'(cell_col),  q[0].col);
                check("code", 32'(cell_code), q[0].code);
                check("last", 32'(cell_last), q[0].last);
                if (rdy[k]) void'(q.pop_front());
            end
            if (k < done_k) begin
                check("max_hold",  32'(max_code),  prev_max);
                check("goal_hold", 32'(goal_seen), prev_goal);
            end
            if (k == 1) check("err_prev", 32'(err), err_m);
            if (k == done_k + 1) begin
                prev_max  = exp_max;
                prev_goal = exp_goal;
                if (bad) err_m = 1;
                check("max_code",  32'(max_code),  prev_max);
                check("goal_seen", 32'(goal_seen), prev_goal);
                check("err",       32'(err),       err_m);
            end
            @(posedge clk); #1;
        end
        frame_start = 1'b0;
    endtask

    initial begin
        rst         = 1'b0;
        frame_start = 1'b0;
        cell_ready  = 1'b0;
        matriz      = '0;
        #2;
        check_idle_outputs("reset");
        #18;
        rst = 1'b1;
        @(posedge clk); #1;

        // Empty board, ready high.
        clear_board();
        run_frame(0, 0, 0);

        // Sparse board reaching the goal.
        clear_board();
        brd[0][0] = 2; brd[1][2] = 64; brd[3][3] = 2048;
        run_frame(0, 0, 0);

        // Full legal board, ready toggling.
        gen_board(0, 0);
        run_frame(1, 0, 0);

        // Board changes and a new request mid-scan must not disturb the frame.
        gen_board(20, 0);
        run_frame(2, 1, 0);

        // Illegal value at [2][1]; err stays set over a following clean frame.
        gen_board(10, 0);
        brd[2][1] = 6;
        run_frame(2, 0, 0);
        gen_board(30, 0);
        run_frame(0, 0, 1);

        // Request that coincides with done is dropped.
        gen_board(40, 0);
        run_frame(0, 0, 1);

        // Two non-empty cells only, then an all-empty board.
        clear_board();
        brd[1][1] = 4; brd[3][0] = 8;
        run_frame(0, 0, 0);
        clear_board();
        run_frame(2, 0, 1);

        // Randomised frames.
        for (int n = 0; n < 12; n++) begin
            gen_board($urandom_range(0, 90), $urandom_range(0, 8));
            run_frame($urandom_range(0, 2), $urandom_range(0, 1), $urandom_range(0, 1));
        end

        // Reset asserted in the middle of a frame.
        gen_board(0, 0);
        brd[0][0] = 2048;
        run_frame(0, 0, 0);
        apply_board();
        frame_start = 1'b1;
        cell_ready  = 1'b1;
        @(posedge clk); #1;
        frame_start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check_idle_outputs("midrst");
        #3;
        rst = 1'b1;
        prev_max  = 0;
        prev_goal = 0;
        err_m     = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            check("rst_done", 32'(done), 0);
            check("rst_busy", 32'(busy), 0);
        end

        // Frame after reset behaves normally.
        gen_board(50, 0);
        run_frame(2, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
